adder_4_arb: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 15 +
 rtl/adder_4_s.sv | 30 +++
 rtl/adder_4_arb.sv | 184 ++++++++++++++++++
 tb/tb_adder_4_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-port add/sub arbiter.
`timescale 1ns/1ps
package adder_arb_pkg;

  localparam int ADD_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } arb_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_4_s.sv
// Combinational 4-bit adder with carry-in and signed overflow flag.
`timescale 1ns/1ps
module adder_4_s
  import adder_arb_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] s,
  output logic             overflow
);

  // Overflow when both addends share a sign that the result does not.
  function automatic logic ovf_chk(input logic signed [ADD_W-1:0] x,
                                   input logic signed [ADD_W-1:0] y,
                                   input logic signed [ADD_W-1:0] r);
    return (x[ADD_W-1] == y[ADD_W-1]) && (r[ADD_W-1] != x[ADD_W-1]);
  endfunction

  logic signed [ADD_W-1:0] a_s;
  logic signed [ADD_W-1:0] b_s;
  logic signed [ADD_W-1:0] sum_s;

  assign a_s      = a;
  assign b_s      = b;
  assign sum_s    = a_s + b_s + $signed({{(ADD_W-1){1'b0}}, cin});
  assign s        = sum_s;
  assign overflow = ovf_chk(a_s, b_s, sum_s);

endmodule

// File: rtl/adder_4_arb.sv
// Two-requester arbiter sharing one adder_4_s; each requester owns a one-deep
// response slot, and a requester with a full slot is not eligible.
`timescale 1ns/1ps
module adder_4_arb
  import adder_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ADD_W-1:0] req0_a,
  input  logic [ADD_W-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ADD_W-1:0] req1_a,
  input  logic [ADD_W-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [ADD_W-1:0] rsp0_s,
  output logic             rsp0_ovf,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [ADD_W-1:0] rsp1_s,
  output logic             rsp1_ovf,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             own_q, own_d;
  logic [ADD_W-1:0] a_q, a_d;
  logic [ADD_W-1:0] b_q, b_d;
  logic             sub_q, sub_d;

  logic [1:0]       req_valid_w;
  logic [1:0]       req_sub_w;
  logic [1:0]       rsp_ready_w;
  logic [ADD_W-1:0] req_a_w [2];
  logic [ADD_W-1:0] req_b_w [2];
  logic [1:0]       rsp_vld_w;
  logic [1:0]       rsp_ovf_w;
  logic [ADD_W-1:0] rsp_s_w [2];

  logic [1:0]       elig;
  logic             gnt_any;
  logic             gnt_id;
  logic [1:0]       gnt_oh;

  logic [ADD_W-1:0] add_b;
  logic             add_cin;
  logic [ADD_W-1:0] add_s;
  logic             add_ovf;

  assign req_valid_w = {req1_valid, req0_valid};
  assign req_sub_w   = {req1_sub, req0_sub};
  assign rsp_ready_w = {rsp1_ready, rsp0_ready};
  assign req_a_w[0]  = req0_a;
  assign req_a_w[1]  = req1_a;
  assign req_b_w[0]  = req0_b;
  assign req_b_w[1]  = req1_b;

  // Eligibility looks at the registered slot state, so a drain and a new
  // request from the same side in one cycle still costs that cycle.
  always_comb begin
    elig    = req_valid_w & ~rsp_vld_w;
    gnt_any = (state_q == ST_IDLE) && (elig != 2'b00);
    if (elig == 2'b11) gnt_id = FAIR ? ~last_q : 1'b0;
    else               gnt_id = elig[1];
    gnt_oh  = 2'b00;
    if (gnt_any) gnt_oh = gnt_id ? 2'b10 : 2'b01;
  end

  assign req0_ready = gnt_oh[0];
  assign req1_ready = gnt_oh[1];

  // Subtraction as a + ~b + 1 through the shared adder.
  assign add_b   = (sub_q == OP_ADD) ? b_q : ~b_q;
  assign add_cin = (sub_q == OP_SUB);

  adder_4_s u_adder (
    .a        (a_q),
    .b        (add_b),
    .cin      (add_cin),
    .s        (add_s),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = ST_EXEC;
          own_d   = gnt_id;
          last_d  = gnt_id;
          a_d     = req_a_w[gnt_id];
          b_d     = req_b_w[gnt_id];
          sub_d   = req_sub_w[gnt_id];
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_EXEC);
  end

  // Last-grant pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
    end
  end

  assign busy = busy_q;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    localparam logic SLOT_ID = 1'(i);
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic [ADD_W-1:0] s_q, s_d;
    logic             wr;

    always_comb begin
      wr    = (state_q == ST_EXEC) && (own_q == SLOT_ID);
      vld_d = vld_q;
      s_d   = s_q;
      ovf_d = ovf_q;
      if (vld_q && rsp_ready_w[i]) vld_d = 1'b0;
      if (wr) begin
        vld_d = 1'b1;
        s_d   = add_s;
        ovf_d = add_ovf;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        ovf_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
        s_q   <= s_d;
        ovf_q <= ovf_d;
      end
    end

    assign rsp_vld_w[i] = vld_q;
    assign rsp_s_w[i]   = s_q;
    assign rsp_ovf_w[i] = ovf_q;
  end

  assign rsp0_valid = rsp_vld_w[0];
  assign rsp1_valid = rsp_vld_w[1];
  assign rsp0_s     = rsp_s_w[0];
  assign rsp1_s     = rsp_s_w[1];
  assign rsp0_ovf   = rsp_ovf_w[0];
  assign rsp1_ovf   = rsp_ovf_w[1];

endmodule

// File: tb/tb_adder_4_arb.sv
// Bench for adder_4_arb: a FAIR=1 and a FAIR=0 instance share stimulus and are
// compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_adder_4_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_sub;
  logic [1:0] rsp_ready;
  logic [3:0] req_a [2];
  logic [3:0] req_b [2];

  logic [1:0] rdy0, rdy1, rv0, rv1, ro0, ro1, bsy;
  logic [3:0] rs0 [2];
  logic [3:0] rs1 [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_4_arb #(.FAIR(1'b1)) dut_fair (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(rdy0[0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_sub(req_sub[0]),
    .req1_valid(req_valid[1]), .req1_ready(rdy1[0]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_sub(req_sub[1]),
    .rsp0_valid(rv0[0]), .rsp0_ready(rsp_ready[0]), .rsp0_s(rs0[0]), .rsp0_ovf(ro0[0]),
    .rsp1_valid(rv1[0]), .rsp1_ready(rsp_ready[1]), .rsp1_s(rs1[0]), .rsp1_ovf(ro1[0]),
    .busy(bsy[0])
  );

  adder_4_arb #(.FAIR(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(rdy0[1]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_sub(req_sub[0]),
    .req1_valid(req_valid[1]), .req1_ready(rdy1[1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_sub(req_sub[1]),
    .rsp0_valid(rv0[1]), .rsp0_ready(rsp_ready[0]), .rsp0_s(rs0[1]), .rsp0_ovf(ro0[1]),
    .rsp1_valid(rv1[1]), .rsp1_ready(rsp_ready[1]), .rsp1_s(rs1[1]), .rsp1_ovf(ro1[1]),
    .busy(bsy[1])
  );

  // ---------------- reference model (index k: 0 = FAIR, 1 = fixed) ----------
  bit         m_busy [2];
  bit         m_own  [2];
  bit         m_last [2];
  bit         m_full [2][2];
  logic [3:0] m_s    [2][2];
  bit         m_ovf  [2][2];
  logic [3:0] m_ps   [2];
  bit         m_povf [2];

  function automatic int sval(input logic [3:0] x);
    return (x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction

  function automatic int ref_res(input logic [3:0] a, input logic [3:0] b, input logic sub);
    return sub ? sval(a) - sval(b) : sval(a) + sval(b);
  endfunction

  function automatic logic [3:0] ref_s(input logic [3:0] a, input logic [3:0] b, input logic sub);
    int r;
    r = ref_res(a, b, sub);
    return 4'(r);
  endfunction

  function automatic bit ref_ovf(input logic [3:0] a, input logic [3:0] b, input logic sub);
    int r;
    r = ref_res(a, b, sub);
    return (r > 7) || (r < -8);
  endfunction

  // Which requester the model grants right now: -1 none.
  function automatic int mdl_grant(input int k);
    bit e0, e1;
    e0 = req_valid[0] && !m_full[k][0];
    e1 = req_valid[1] && !m_full[k][1];
    if (m_busy[k]) return -1;
    if (e0 && e1) return (k == 1) ? 0 : (m_last[k] ? 0 : 1);
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0; m_own[k] <= 1'b0; m_last[k] <= 1'b1;
        m_ps[k] <= 4'd0; m_povf[k] <= 1'b0;
        for (int j = 0; j < 2; j++) begin
          m_full[k][j] <= 1'b0; m_s[k][j] <= 4'd0; m_ovf[k][j] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++)
          if (m_full[k][j] && rsp_ready[j]) m_full[k][j] <= 1'b0;
        if (m_busy[k]) begin
          m_full[k][m_own[k]] <= 1'b1;
          m_s[k][m_own[k]]    <= m_ps[k];
          m_ovf[k][m_own[k]]  <= m_povf[k];
          m_busy[k]           <= 1'b0;
        end else if (mdl_grant(k) >= 0) begin
          m_busy[k] <= 1'b1;
          m_own[k]  <= (mdl_grant(k) == 1);
          m_last[k] <= (mdl_grant(k) == 1);
          m_ps[k]   <= ref_s(req_a[mdl_grant(k)], req_b[mdl_grant(k)], req_sub[mdl_grant(k)]);
          m_povf[k] <= ref_ovf(req_a[mdl_grant(k)], req_b[mdl_grant(k)], req_sub[mdl_grant(k)]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic pulse_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated operation on requester id, observed on the FAIR instance.
  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic sub,
                        output logic rdy, output logic early, output logic bsy_e,
                        output logic vld, output logic [3:0] s, output logic ovf);
    req_a[id] = a; req_b[id] = b; req_sub[id] = sub; req_valid[id] = 1'b1;
    #1 rdy = id ? rdy1[0] : rdy0[0];
    @(negedge clk);
    req_valid[id] = 1'b0;
    early = id ? rv1[0] : rv0[0];
    bsy_e = bsy[0];
    @(negedge clk);
    vld = id ? rv1[0] : rv0[0];
    s   = id ? rs1[0] : rs0[0];
    ovf = id ? ro1[0] : ro0[0];
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready[id] = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; req_sub = 2'b00;
    req_a[0] = 4'd0; req_a[1] = 4'd0; req_b[0] = 4'd0; req_b[1] = 4'd0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (bsy[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got %b want 0", k, bsy[k]); end
      n_cmp++; if ({rv1[k], rv0[k]} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid[%0d] got %b want 00", k, {rv1[k], rv0[k]}); end
      n_cmp++; if ({rs1[k], rs0[k], ro1[k], ro0[k]} !== 10'd0) begin n_err++; $display("FAIL reset_rsp_data[%0d] got %h want 0", k, {rs1[k], rs0[k], ro1[k], ro0[k]}); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if ({rdy1[k], rdy0[k]} !== 2'b01) begin n_err++; $display("FAIL first_tie[%0d] got %b want 01", k, {rdy1[k], rdy0[k]}); end
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  typedef struct {
    int         id;
    logic [3:0] a, b;
    logic       sub;
    logic [3:0] s;
    logic       ovf;
  } op_t;

  task automatic test_directed_ops();
    op_t ops [8];
    logic rdy, early, bsy_e, vld, ovf;
    logic [3:0] s;
    ops[0] = '{0, 4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0};
    ops[1] = '{1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b1};
    ops[2] = '{1, 4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1};
    ops[3] = '{0, 4'b0011, 4'b0110, 1'b0, 4'b1001, 1'b1};
    ops[4] = '{1, 4'b0000, 4'b1000, 1'b1, 4'b1000, 1'b1};
    ops[5] = '{0, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b0};
    ops[6] = '{0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b0};
    ops[7] = '{1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1};
    foreach (ops[i]) begin
      run_op(ops[i].id, ops[i].a, ops[i].b, ops[i].sub, rdy, early, bsy_e, vld, s, ovf);
      n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL op%0d_ready got %b want 1", i, rdy); end
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL op%0d_early_valid got %b want 0", i, early); end
      n_cmp++; if (bsy_e !== 1'b1) begin n_err++; $display("FAIL op%0d_busy got %b want 1", i, bsy_e); end
      n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL op%0d_rsp_valid got %b want 1", i, vld); end
      n_cmp++; if (s !== ops[i].s) begin n_err++; $display("FAIL op%0d_s got %b want %b", i, s, ops[i].s); end
      n_cmp++; if (ovf !== ops[i].ovf) begin n_err++; $display("FAIL op%0d_ovf got %b want %b", i, ovf, ops[i].ovf); end
    end
  endtask

  task automatic test_alternate();
    int g [2][4];
    int n [2];
    pulse_reset();
    n[0] = 0; n[1] = 0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 2; j++) begin
        req_a[j] = 4'($urandom); req_b[j] = 4'($urandom); req_sub[j] = 1'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++)
        if ((rdy0[k] || rdy1[k]) && n[k] < 4) begin g[k][n[k]] = rdy1[k] ? 1 : 0; n[k]++; end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (n[k] != 4) begin n_err++; $display("FAIL alt_grant_count[%0d] got %0d want 4", k, n[k]); end
      for (int i = 0; i < n[k]; i++) begin
        n_cmp++; if (g[k][i] != (i % 2)) begin n_err++; $display("FAIL alt_grant[%0d][%0d] got %0d want %0d", k, i, g[k][i], i % 2); end
      end
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ties();
    int want;
    pulse_reset();
    rsp_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 2; k++) begin
        want = (k == 0) ? (t % 2) : 0;
        n_cmp++;
        if ({rdy1[k], rdy0[k]} !== ((want == 1) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL tie%0d_grant[%0d] got %b want requester %0d", t, k, {rdy1[k], rdy0[k]}, want);
        end
      end
      @(negedge clk);
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int acc0 [2];
    int acc1 [2];
    pulse_reset();
    acc0[0] = 0; acc0[1] = 0; acc1[0] = 0; acc1[1] = 0;
    req_valid = 2'b11;
    for (int c = 0; c < 15; c++) begin
      rsp_ready = (c >= 13) ? 2'b11 : 2'b10;
      for (int j = 0; j < 2; j++) begin
        req_a[j] = 4'($urandom); req_b[j] = 4'($urandom); req_sub[j] = 1'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy0[k] !== (mdl_grant(k) == 0) || rdy1[k] !== (mdl_grant(k) == 1)) begin
          n_err++; $display("FAIL bp_ready[%0d] c%0d got %b want grant %0d", k, c, {rdy1[k], rdy0[k]}, mdl_grant(k));
        end
        if (c < 13) begin
          if (rdy0[k]) acc0[k]++;
          if (rdy1[k]) acc1[k]++;
        end
        if (c == 13) begin
          n_cmp++; if (rdy0[k] !== 1'b0) begin n_err++; $display("FAIL bp_same_cycle_accept[%0d] got %b want 0", k, rdy0[k]); end
        end
        if (c == 14) begin
          n_cmp++; if (rdy0[k] !== 1'b1) begin n_err++; $display("FAIL bp_next_accept[%0d] got %b want 1", k, rdy0[k]); end
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (acc0[k] != 1) begin n_err++; $display("FAIL bp_req0_accepts[%0d] got %0d want 1", k, acc0[k]); end
      n_cmp++; if (acc1[k] != 4) begin n_err++; $display("FAIL bp_req1_accepts[%0d] got %0d want 4", k, acc1[k]); end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (bsy[k] !== m_busy[k]) begin n_err++; $display("FAIL rnd_busy[%0d] c%0d got %b want %b", k, c, bsy[k], m_busy[k]); end
        n_cmp++; if ({rv1[k], rv0[k]} !== {m_full[k][1], m_full[k][0]}) begin n_err++; $display("FAIL rnd_rsp_valid[%0d] c%0d got %b want %b", k, c, {rv1[k], rv0[k]}, {m_full[k][1], m_full[k][0]}); end
        n_cmp++; if (rs0[k] !== m_s[k][0] || ro0[k] !== m_ovf[k][0]) begin n_err++; $display("FAIL rnd_rsp0[%0d] c%0d got %b/%b want %b/%b", k, c, rs0[k], ro0[k], m_s[k][0], m_ovf[k][0]); end
        n_cmp++; if (rs1[k] !== m_s[k][1] || ro1[k] !== m_ovf[k][1]) begin n_err++; $display("FAIL rnd_rsp1[%0d] c%0d got %b/%b want %b/%b", k, c, rs1[k], ro1[k], m_s[k][1], m_ovf[k][1]); end
      end
      for (int j = 0; j < 2; j++) begin
        req_valid[j] = ($urandom_range(0, 3) != 0);
        rsp_ready[j] = ($urandom_range(0, 2) != 0);
        req_a[j] = 4'($urandom); req_b[j] = 4'($urandom); req_sub[j] = 1'($urandom);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (rdy0[k] !== (mdl_grant(k) == 0) || rdy1[k] !== (mdl_grant(k) == 1)) begin
          n_err++; $display("FAIL rnd_ready[%0d] c%0d got %b want grant %0d", k, c, {rdy1[k], rdy0[k]}, mdl_grant(k));
        end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    rsp_ready = 2'b00;
    req_a[1] = 4'b0010; req_b[1] = 4'b0011; req_sub[1] = 1'b0;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_a[0] = 4'b0110; req_b[0] = 4'b0001; req_sub[0] = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (bsy[k] !== 1'b1) begin n_err++; $display("FAIL mid_busy_before[%0d] got %b want 1", k, bsy[k]); end
      n_cmp++; if (rv1[k] !== 1'b1 || rs1[k] !== 4'b0101) begin n_err++; $display("FAIL mid_rsp1_before[%0d] got %b/%b want 1/0101", k, rv1[k], rs1[k]); end
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (bsy[k] !== 1'b0) begin n_err++; $display("FAIL mid_busy_reset[%0d] got %b want 0", k, bsy[k]); end
      n_cmp++; if ({rv1[k], rv0[k]} !== 2'b00) begin n_err++; $display("FAIL mid_valid_reset[%0d] got %b want 00", k, {rv1[k], rv0[k]}); end
      n_cmp++; if (rs1[k] !== 4'd0) begin n_err++; $display("FAIL mid_s1_reset[%0d] got %b want 0000", k, rs1[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({bsy[k], rv1[k], rv0[k]} !== 3'b000) begin
          n_err++; $display("FAIL mid_after_release[%0d] c%0d got %b want 000", k, c, {bsy[k], rv1[k], rv0[k]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_ops();
    test_alternate();
    test_ties();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
